// File: rtl/color_descrambler.sv
// color_descrambler: undoes the RGB444 channel swap applied earlier in the VGA path.
// The switch code is synchronised, debounced and committed only on the vsync
// leading edge. Pixels, syncs and valid leave two clocks after they arrive.
// Optional build macro COLOR_DESCR_ERRCNT_EN adds err_frames, a saturating count
// of frames committed with a non-invertible code.
module color_descrambler #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic        VS_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] SW_cs,
  input  logic       pix_valid_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [3:0] R_in,
  input  logic [3:0] G_in,
  input  logic [3:0] B_in,
  output logic [3:0] R_out,
  output logic [3:0] G_out,
  output logic [3:0] B_out,
  output logic       pix_valid_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       map_valid
`ifdef COLOR_DESCR_ERRCNT_EN
  ,
  output logic [7:0] err_frames
`endif
);

  localparam int          DATA_W    = 4;
  localparam logic [5:0]  IDENT     = 6'b00_01_10;
  localparam logic        SYNC_IDLE = VS_ACTIVE_LOW;
  localparam logic        VS_ACTIVE = ~VS_ACTIVE_LOW;

  // Stability counter step, held at DEBOUNCE_CYCLES once reached.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c >= DEBOUNCE_CYCLES) ? DEBOUNCE_CYCLES : c + 16'd1;
  endfunction

  // Error-frame counter step, held at 8'hFF once reached.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Which scrambled channel carries original channel x (0=R_in,1=G_in,2=B_in,3=none).
  // Lower scrambled index wins when several channels carry the same original.
  function automatic logic [1:0] inv_sel(input logic [5:0] code, input logic [1:0] x);
    if (code[5:4] == x)      return 2'd0;
    else if (code[3:2] == x) return 2'd1;
    else if (code[1:0] == x) return 2'd2;
    else                     return 2'd3;
  endfunction

  // A code is invertible only when it is a true permutation of R, G, B.
  function automatic logic code_ok(input logic [5:0] code);
    return (code[5:4] != 2'd3) && (code[3:2] != 2'd3) && (code[1:0] != 2'd3) &&
           (code[5:4] != code[3:2]) && (code[5:4] != code[1:0]) &&
           (code[3:2] != code[1:0]);
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel,
                                             input logic [DATA_W-1:0] r,
                                             input logic [DATA_W-1:0] g,
                                             input logic [DATA_W-1:0] b);
    case (sel)
      2'd0:    return r;
      2'd1:    return g;
      2'd2:    return b;
      default: return '0;
    endcase
  endfunction

  logic [5:0]  sw_meta, sw_sync, sw_cand, pend_code, act_code;
  logic [15:0] db_cnt, db_cnt_inc;
  logic        vs_edge;
  logic [1:0]  sel_r, sel_g, sel_b;

  logic [DATA_W-1:0] r_p1, g_p1, b_p1;
  logic              vld_p1, hs_p1, vs_p1;

  assign db_cnt_inc = sat_inc(db_cnt);
  // vs_p1 holds the previous vsync sample, so this is the leading edge of the active level.
  assign vs_edge    = (vsync_in == VS_ACTIVE) && (vs_p1 != VS_ACTIVE);

  // Switch synchroniser and debouncer: a code becomes pending once it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= IDENT;
      sw_sync   <= IDENT;
      sw_cand   <= IDENT;
      db_cnt    <= '0;
      pend_code <= IDENT;
    end else begin
      sw_meta <= SW_cs;
      sw_sync <= sw_meta;
      if (sw_sync != sw_cand) begin
        sw_cand <= sw_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt_inc;
        if (db_cnt_inc == DEBOUNCE_CYCLES) pend_code <= sw_cand;
      end
    end
  end

  // Frame-boundary commit: the pending code (as it was before this edge) becomes active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_code <= IDENT;
    end else if (vs_edge) begin
      act_code <= pend_code;
    end
  end

`ifdef COLOR_DESCR_ERRCNT_EN
  // Count frames committed with a code that cannot be fully inverted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frames <= '0;
    end else if (vs_edge && !code_ok(pend_code)) begin
      err_frames <= sat_inc8(err_frames);
    end
  end
`endif

  // Inverse selects and invertibility flag decoded from the active code.
  always_comb begin
    sel_r     = inv_sel(act_code, 2'd0);
    sel_g     = inv_sel(act_code, 2'd1);
    sel_b     = inv_sel(act_code, 2'd2);
    map_valid = code_ok(act_code);
  end

  // Stage 1: register pixel, syncs and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= SYNC_IDLE;
      vs_p1  <= SYNC_IDLE;
    end else begin
      r_p1   <= R_in;
      g_p1   <= G_in;
      b_p1   <= B_in;
      vld_p1 <= pix_valid_in;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
    end
  end

  // Stage 2: inverse channel mux with blanking, registered onto the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_out         <= '0;
      G_out         <= '0;
      B_out         <= '0;
      pix_valid_out <= 1'b0;
      hsync_out     <= SYNC_IDLE;
      vsync_out     <= SYNC_IDLE;
    end else begin
      R_out         <= vld_p1 ? pick(sel_r, r_p1, g_p1, b_p1) : '0;
      G_out         <= vld_p1 ? pick(sel_g, r_p1, g_p1, b_p1) : '0;
      B_out         <= vld_p1 ? pick(sel_b, r_p1, g_p1, b_p1) : '0;
      pix_valid_out <= vld_p1;
      hsync_out     <= hs_p1;
      vsync_out     <= vs_p1;
    end
  end

endmodule

// File: tb/tb_color_descrambler.sv
// Testbench for color_descrambler (DEBOUNCE_CYCLES=4, active-low syncs).
// Directed table of codes, hand sequences for debounce/commit/reset corners,
// and a randomized run, all checked against a behavioural model.
module tb_color_descrambler;

  localparam int         D      = 4;
  localparam logic       VS_ACT = 1'b0;
  localparam logic       IDLE   = 1'b1;
  localparam logic [5:0] IDENT  = 6'h06;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] SW_cs;
  logic       pix_valid_in, hsync_in, vsync_in;
  logic [3:0] R_in, G_in, B_in;
  logic [3:0] R_out, G_out, B_out;
  logic       pix_valid_out, hsync_out, vsync_out, map_valid;
`ifdef COLOR_DESCR_ERRCNT_EN
  logic [7:0] err_frames;
`endif

  always #5 clk = ~clk;

  color_descrambler #(.DEBOUNCE_CYCLES(16'd4), .VS_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .SW_cs(SW_cs),
    .pix_valid_in(pix_valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .pix_valid_out(pix_valid_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .map_valid(map_valid)
`ifdef COLOR_DESCR_ERRCNT_EN
    , .err_frames(err_frames)
`endif
  );

  typedef struct {
    logic [5:0] code;
    logic [3:0] r, g, b;
    logic [3:0] er, eg, eb;
    logic       emv;
  } vec_t;

  typedef struct {
    logic [3:0] r, g, b;
    logic       vld, hs, vs;
  } pix_t;

  vec_t tbl[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state
  logic [5:0] m_pending, m_active;
  logic       m_vs_prev;
  int         m_err;
  logic [5:0] hist[$];
  pix_t       exp_s1, exp_out;

  // Original channel X is the scrambled channel whose forward select equals X;
  // scan B, G, R so the lowest index overwrites last and wins.
  function automatic logic [11:0] inv_model(input logic [5:0] code,
                                            input logic [3:0] r, g, b);
    logic [3:0] src[3];
    logic [1:0] fsel[3];
    logic [3:0] orig[3];
    src[0] = r; src[1] = g; src[2] = b;
    fsel[0] = code[5:4]; fsel[1] = code[3:2]; fsel[2] = code[1:0];
    for (int x = 0; x < 3; x++) begin
      orig[x] = 4'd0;
      for (int y = 2; y >= 0; y--)
        if (fsel[y] == 2'(x)) orig[x] = src[y];
    end
    return {orig[0], orig[1], orig[2]};
  endfunction

  // Invertible when every original channel is selected exactly once.
  function automatic logic valid_model(input logic [5:0] code);
    int cnt[4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    cnt[code[5:4]]++; cnt[code[3:2]]++; cnt[code[1:0]]++;
    return (cnt[0] == 1) && (cnt[1] == 1) && (cnt[2] == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = IDENT;
    m_active  = IDENT;
    m_vs_prev = IDLE;
    m_err     = 0;
    hist.delete();
    exp_s1.r = 4'd0; exp_s1.g = 4'd0; exp_s1.b = 4'd0;
    exp_s1.vld = 1'b0; exp_s1.hs = IDLE; exp_s1.vs = IDLE;
    exp_out = exp_s1;
  endtask

  // One active clock edge of the model, using the inputs presented before it.
  task automatic model_edge();
    logic commit;
    logic same;
    int   base;
    commit = (vsync_in == VS_ACT) && (m_vs_prev != VS_ACT);
    if (commit) begin
      m_active = m_pending;
      if (!valid_model(m_active) && m_err < 255) m_err++;
    end
    m_vs_prev = vsync_in;
    // Switch value seen by the debouncer lags two samples; it must have been
    // the same for D+1 consecutive samples to become pending.
    hist.push_back(SW_cs);
    if (hist.size() > 64) void'(hist.pop_front());
    if (hist.size() >= D + 3) begin
      base = hist.size() - 3 - D;
      same = 1'b1;
      for (int i = 1; i <= D; i++)
        if (hist[base + i] != hist[base]) same = 1'b0;
      if (same) m_pending = hist[base];
    end
    exp_out    = exp_s1;
    exp_s1.vld = pix_valid_in;
    exp_s1.hs  = hsync_in;
    exp_s1.vs  = vsync_in;
    {exp_s1.r, exp_s1.g, exp_s1.b} = pix_valid_in ? inv_model(m_active, R_in, G_in, B_in) : 12'h000;
  endtask

  task automatic compare_all();
    chk("r_out",     int'(R_out),         int'(exp_out.r));
    chk("g_out",     int'(G_out),         int'(exp_out.g));
    chk("b_out",     int'(B_out),         int'(exp_out.b));
    chk("valid_out", int'(pix_valid_out), int'(exp_out.vld));
    chk("hsync_out", int'(hsync_out),     int'(exp_out.hs));
    chk("vsync_out", int'(vsync_out),     int'(exp_out.vs));
    chk("map_valid", int'(map_valid),     int'(valid_model(m_active)));
`ifdef COLOR_DESCR_ERRCNT_EN
    chk("err_frames", int'(err_frames), m_err);
`endif
  endtask

  task automatic tick(input bit do_chk);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    if (do_chk) compare_all();
  endtask

  task automatic set_pix(input logic vld, input logic [3:0] r, g, b);
    pix_valid_in = vld; R_in = r; G_in = g; B_in = b;
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, g, b);
    chk({tag, "_r"}, int'(R_out), int'(r));
    chk({tag, "_g"}, int'(G_out), int'(g));
    chk({tag, "_b"}, int'(B_out), int'(b));
  endtask

  // Make a code pending, commit it on a vsync edge, push one pixel through.
  task automatic apply_code(input vec_t v);
    SW_cs = v.code; vsync_in = IDLE; hsync_in = IDLE; set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    repeat (10) tick(1);
    vsync_in = VS_ACT;
    tick(1);
    set_pix(1'b1, v.r, v.g, v.b);
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("tbl", v.er, v.eg, v.eb);
    chk("tbl_mv", int'(map_valid), int'(v.emv));
  endtask

  initial begin
    tbl[0] = '{6'h06, 4'd9, 4'd3, 4'd5, 4'd9, 4'd3, 4'd5, 1'b1};
    tbl[1] = '{6'h21, 4'd9, 4'd3, 4'd5, 4'd3, 4'd5, 4'd9, 1'b1};
    tbl[2] = '{6'h12, 4'd9, 4'd3, 4'd5, 4'd3, 4'd9, 4'd5, 1'b1};
    tbl[3] = '{6'h24, 4'd9, 4'd3, 4'd5, 4'd5, 4'd3, 4'd9, 1'b1};
    tbl[4] = '{6'h09, 4'd9, 4'd3, 4'd5, 4'd9, 4'd5, 4'd3, 1'b1};
    tbl[5] = '{6'h35, 4'd9, 4'd3, 4'd5, 4'd0, 4'd3, 4'd0, 1'b0};
    tbl[6] = '{6'h17, 4'd9, 4'd3, 4'd5, 4'd0, 4'd9, 4'd0, 1'b0};
    tbl[7] = '{6'h28, 4'd9, 4'd3, 4'd5, 4'd5, 4'd0, 4'd9, 1'b0};
    tbl[8] = '{6'h3F, 4'd9, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0};

    // Reset state
    rst_n = 1'b0; SW_cs = IDENT; hsync_in = IDLE; vsync_in = IDLE;
    set_pix(1'b1, 4'd3, 4'd5, 4'd9);
    model_reset();
    repeat (3) tick(0);
    chk("rst_r", int'(R_out), 0);
    chk("rst_valid", int'(pix_valid_out), 0);
    chk("rst_hsync", int'(hsync_out), int'(IDLE));
    chk("rst_vsync", int'(vsync_out), int'(IDLE));
    chk("rst_mv", int'(map_valid), 1);
    rst_n = 1'b1;

    // Identity pass-through, latency 2
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("t1", 4'd3, 4'd5, 4'd9);
    chk("t1_valid", int'(pix_valid_out), 1);
    chk("t1_mv", int'(map_valid), 1);

    // Code table, including invalid codes
    for (int i = 0; i < 9; i++) apply_code(tbl[i]);
`ifdef COLOR_DESCR_ERRCNT_EN
    chk("err_tbl", int'(err_frames), 4);
`endif

    // Blanking and sync delay
    hsync_in = VS_ACT; vsync_in = IDLE; set_pix(1'b0, 4'hF, 4'hF, 4'hF);
    tick(1);
    hsync_in = IDLE; vsync_in = VS_ACT;
    tick(1);
    chk("blank_hs", int'(hsync_out), int'(VS_ACT));
    chk("blank_vs", int'(vsync_out), int'(IDLE));
    chk_rgb("blank", 4'd0, 4'd0, 4'd0);
    vsync_in = IDLE;
    tick(1);
    chk("blank_hs2", int'(hsync_out), int'(IDLE));
    chk("blank_vs2", int'(vsync_out), int'(VS_ACT));
    chk_rgb("blank2", 4'd0, 4'd0, 4'd0);

    // Switch bounce mid-frame never becomes pending
    apply_code(tbl[1]);
    vsync_in = IDLE;
    for (int i = 0; i < 10; i++) begin
      SW_cs = i[0] ? tbl[3].code : tbl[2].code;
      repeat (2) tick(1);
    end
    vsync_in = VS_ACT; set_pix(1'b1, 4'd9, 4'd3, 4'd5);
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("bounce", 4'd3, 4'd5, 4'd9);
    vsync_in = IDLE; SW_cs = tbl[4].code;
    repeat (10) tick(1);
    vsync_in = VS_ACT; set_pix(1'b1, 4'd9, 4'd3, 4'd5);
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("held", 4'd9, 4'd5, 4'd3);

    // Pending updated on the commit edge: old pending is committed
    vsync_in = IDLE; SW_cs = tbl[2].code;
    repeat (6) tick(1);
    vsync_in = VS_ACT; set_pix(1'b1, 4'd9, 4'd3, 4'd5);
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("oldpend", 4'd9, 4'd5, 4'd3);
    vsync_in = IDLE;
    repeat (3) tick(1);
    vsync_in = VS_ACT; set_pix(1'b1, 4'd9, 4'd3, 4'd5);
    tick(1);
    set_pix(1'b0, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_rgb("newpend", 4'd3, 4'd9, 4'd5);

    // Randomized traffic
    begin
      int hold = 0;
      for (int i = 0; i < 800; i++) begin
        if (hold == 0) begin
          SW_cs = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 8)].code
                                              : 6'($urandom_range(0, 63));
          hold  = $urandom_range(1, 12);
        end
        hold--;
        vsync_in = ((i % 37) < 3) ? VS_ACT : IDLE;
        hsync_in = ((i % 11) == 0) ? VS_ACT : IDLE;
        set_pix($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        tick(1);
      end
    end

    // Reset mid-line with a non-identity code active
    apply_code(tbl[1]);
    vsync_in = IDLE; set_pix(1'b1, 4'd9, 4'd3, 4'd5);
    repeat (3) tick(1);
    chk_rgb("t6_pre", 4'd3, 4'd5, 4'd9);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_rgb("t6_rst", 4'd0, 4'd0, 4'd0);
    chk("t6_rst_valid", int'(pix_valid_out), 0);
    chk("t6_rst_hs", int'(hsync_out), int'(IDLE));
    chk("t6_rst_vs", int'(vsync_out), int'(IDLE));
    chk("t6_rst_mv", int'(map_valid), 1);
    repeat (2) tick(0);
    rst_n = 1'b1;
    tick(1);
    tick(1);
    chk_rgb("t6_post", 4'd9, 4'd3, 4'd5);
    repeat (3) tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
